sfp_link_sequencer: RTL and testbench

// Bring-up/recovery sequencer for one SFP+ cage and its Arria 10 USXGMII transceiver PHY.

---
 rtl/sfp_link_sequencer_if.sv | 33 +++
 rtl/sfp_link_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sfp_link_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfp_link_sequencer_if.sv
// Sideband and status bundle between the SFP/PHY control path and the link sequencer.
// master = sequencer side, slave = cage/PHY/status side.
interface sfp_link_sequencer_if #(
    parameter int P_MAX_RETRY = 3
);
    localparam int RW = $clog2(P_MAX_RETRY + 1);

    logic          i_sfp_los;
    logic          i_sfp_tx_fault;
    logic          i_sfp_mod0_prsnt_n;
    logic          i_phy_rx_ready;
    logic          i_phy_tx_ready;
    logic          o_sfp_tx_disable;
    logic          o_phy_reset_n;
    logic          o_link_up;
    logic          o_fault;
    logic [2:0]    o_state;
    logic [RW-1:0] o_retry_count;

    modport master (
        input  i_sfp_los, i_sfp_tx_fault, i_sfp_mod0_prsnt_n,
        input  i_phy_rx_ready, i_phy_tx_ready,
        output o_sfp_tx_disable, o_phy_reset_n, o_link_up,
        output o_fault, o_state, o_retry_count
    );

    modport slave (
        output i_sfp_los, i_sfp_tx_fault, i_sfp_mod0_prsnt_n,
        output i_phy_rx_ready, i_phy_tx_ready,
        input  o_sfp_tx_disable, o_phy_reset_n, o_link_up,
        input  o_fault, o_state, o_retry_count
    );
endinterface

// File: rtl/sfp_link_sequencer.sv
// SFP+ cage / USXGMII PHY bring-up and recovery sequencer.
// Define SFP_TX_FAULT_RETRY_EN to retry TX_FAULT up to P_MAX_RETRY times; otherwise FAULT is sticky.
module sfp_link_sequencer #(
    parameter int P_DEBOUNCE_CYCLES = 1024,
    parameter int P_TX_DIS_CYCLES   = 2000,
    parameter int P_PHY_RST_CYCLES  = 256,
    parameter int P_LOCK_TIMEOUT    = 1000000,
    parameter int P_MAX_RETRY       = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    sfp_link_sequencer_if.master bus
);
    localparam logic [2:0] ST_ABSENT    = 3'd0;
    localparam logic [2:0] ST_TX_OFF    = 3'd1;
    localparam logic [2:0] ST_PHY_RST   = 3'd2;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd3;
    localparam logic [2:0] ST_LINK_UP   = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int MAX_A = (P_TX_DIS_CYCLES > P_PHY_RST_CYCLES) ?
                           P_TX_DIS_CYCLES : P_PHY_RST_CYCLES;
    localparam int MAX_T = (MAX_A > P_LOCK_TIMEOUT) ? MAX_A : P_LOCK_TIMEOUT;
    localparam int TW    = $clog2(MAX_T) + 1;
    localparam int DW    = $clog2(P_DEBOUNCE_CYCLES + 1);
    localparam int RW    = $clog2(P_MAX_RETRY + 1);

    // Pin vector order {prsnt_n, tx_fault, los}; idle value = absent, no fault, no signal.
    localparam logic [2:0] PIN_IDLE = 3'b101;

    logic [2:0]    pins;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    filt_d, filt_q;
    logic [DW-1:0] db_cnt_d [3];
    logic [DW-1:0] db_cnt_q [3];

    logic [2:0]    state_d, state_q;
    logic [TW-1:0] timer_d, timer_q;
    logic          tmr_zero;
    logic          lock_ok;
    logic          los_f, tx_fault_f, prsnt_n_f;

    logic          tx_dis_d, tx_dis_q;
    logic          phy_rst_n_d, phy_rst_n_q;
    logic          link_up_d, link_up_q;
    logic          fault_d, fault_q;
    logic [2:0]    state_o_d, state_o_q;

    assign pins = {bus.i_sfp_mod0_prsnt_n, bus.i_sfp_tx_fault, bus.i_sfp_los};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_d[i]   = filt_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DW'(P_DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign los_f      = filt_q[0];
    assign tx_fault_f = filt_q[1];
    assign prsnt_n_f  = filt_q[2];
    assign lock_ok    = bus.i_phy_rx_ready & bus.i_phy_tx_ready & ~los_f;
    assign tmr_zero   = (timer_q == '0);

    function automatic logic [TW-1:0] load_val(input logic [2:0] s);
        case (s)
            ST_TX_OFF, ST_FAULT: load_val = TW'(P_TX_DIS_CYCLES - 1);
            ST_PHY_RST:          load_val = TW'(P_PHY_RST_CYCLES - 1);
            ST_WAIT_LOCK:        load_val = TW'(P_LOCK_TIMEOUT - 1);
            default:             load_val = '0;
        endcase
    endfunction

`ifdef SFP_TX_FAULT_RETRY_EN
    logic [RW-1:0] retry_d, retry_q;
    logic          fault_exit;

    assign fault_exit = tmr_zero && (retry_q < RW'(P_MAX_RETRY));
`else
    logic fault_exit;

    assign fault_exit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (prsnt_n_f) begin
            state_d = ST_ABSENT;
        end else if (tx_fault_f && (state_q == ST_PHY_RST ||
                                    state_q == ST_WAIT_LOCK ||
                                    state_q == ST_LINK_UP)) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_ABSENT:    state_d = ST_TX_OFF;
                ST_TX_OFF:    if (tmr_zero) state_d = ST_PHY_RST;
                ST_PHY_RST:   if (tmr_zero) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_ok)       state_d = ST_LINK_UP;
                    else if (tmr_zero) state_d = ST_PHY_RST;
                end
                ST_LINK_UP:   if (!lock_ok) state_d = ST_WAIT_LOCK;
                ST_FAULT:     if (fault_exit) state_d = ST_TX_OFF;
                default:      state_d = ST_ABSENT;
            endcase
        end
    end

    // Every state entry reloads the shared timer; otherwise count down to zero and hold.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = load_val(state_d);
        end else if (!tmr_zero) begin
            timer_d = timer_q - 1'b1;
        end
    end

`ifdef SFP_TX_FAULT_RETRY_EN
    always_comb begin
        retry_d = retry_q;
        if (state_d == ST_ABSENT) begin
            retry_d = '0;
        end else if (state_q == ST_FAULT && state_d == ST_TX_OFF) begin
            retry_d = retry_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) retry_q <= '0;
        else            retry_q <= retry_d;
    end

    assign bus.o_retry_count = retry_q;
`else
    assign bus.o_retry_count = '0;
`endif

    always_comb begin
        tx_dis_d    = 1'b1;
        phy_rst_n_d = 1'b0;
        link_up_d   = 1'b0;
        fault_d     = 1'b0;
        state_o_d   = state_q;
        case (state_q)
            ST_PHY_RST:   tx_dis_d = 1'b0;
            ST_WAIT_LOCK: begin
                tx_dis_d    = 1'b0;
                phy_rst_n_d = 1'b1;
            end
            ST_LINK_UP:   begin
                tx_dis_d    = 1'b0;
                phy_rst_n_d = 1'b1;
                link_up_d   = 1'b1;
            end
            ST_FAULT:     fault_d = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync1_q     <= PIN_IDLE;
            sync2_q     <= PIN_IDLE;
            filt_q      <= PIN_IDLE;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            state_q     <= ST_ABSENT;
            timer_q     <= '0;
            tx_dis_q    <= 1'b1;
            phy_rst_n_q <= 1'b0;
            link_up_q   <= 1'b0;
            fault_q     <= 1'b0;
            state_o_q   <= ST_ABSENT;
        end else begin
            sync1_q     <= pins;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q     <= state_d;
            timer_q     <= timer_d;
            tx_dis_q    <= tx_dis_d;
            phy_rst_n_q <= phy_rst_n_d;
            link_up_q   <= link_up_d;
            fault_q     <= fault_d;
            state_o_q   <= state_o_d;
        end
    end

    assign bus.o_sfp_tx_disable = tx_dis_q;
    assign bus.o_phy_reset_n    = phy_rst_n_q;
    assign bus.o_link_up        = link_up_q;
    assign bus.o_fault          = fault_q;
    assign bus.o_state          = state_o_q;
endmodule

// File: tb/tb_sfp_link_sequencer.sv
// Self-checking bench for sfp_link_sequencer: expected state/output events are queued
// with their cycle spacing and matched against each observed o_state change.
module tb_sfp_link_sequencer;
    localparam int DB = 4;
    localparam int TXD = 8;
    localparam int PR = 4;
    localparam int LT = 32;
    localparam int MR = 2;

    typedef struct {
        logic [2:0] st;
        int         dly;
        logic [3:0] o;
        logic [1:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rl_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sfp_link_sequencer_if #(.P_MAX_RETRY(MR)) bus();

    sfp_link_sequencer #(
        .P_DEBOUNCE_CYCLES(DB),
        .P_TX_DIS_CYCLES(TXD),
        .P_PHY_RST_CYCLES(PR),
        .P_LOCK_TIMEOUT(LT),
        .P_MAX_RETRY(MR)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    always @(negedge clk) if (bus.o_phy_reset_n === 1'b0) rl_cnt++;

    // Expected {tx_disable, phy_reset_n, link_up, fault} per state.
    function automatic exp_t mk(logic [2:0] st, int dly, logic [1:0] rc);
        exp_t e;
        e.st = st;
        e.dly = dly;
        e.rc = rc;
        case (st)
            3'd2:    e.o = 4'b0000;
            3'd3:    e.o = 4'b0100;
            3'd4:    e.o = 4'b0110;
            3'd5:    e.o = 4'b1001;
            default: e.o = 4'b1000;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] outs();
        return {bus.o_sfp_tx_disable, bus.o_phy_reset_n, bus.o_link_up, bus.o_fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until o_state changes, or -1 if it holds for lim cycles.
    task automatic next_change(input int lim, output int n);
        logic [2:0] p;
        p = bus.o_state;
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.o_state !== p) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_sfp_los = 1'b1;
        bus.i_sfp_tx_fault = 1'b0;
        bus.i_sfp_mod0_prsnt_n = 1'b1;
        bus.i_phy_rx_ready = 1'b0;
        bus.i_phy_tx_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.o_state !== 3'd0 || outs() !== 4'b1000 || bus.o_retry_count !== 2'd0) begin
            errors++;
            $display("FAIL reset: state=%0d outs=%b rc=%0d, want state=0 outs=1000 rc=0",
                     bus.o_state, outs(), bus.o_retry_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        bus.i_sfp_mod0_prsnt_n = 1'b0;
        repeat (3) tick();
        bus.i_sfp_mod0_prsnt_n = 1'b1;
        repeat (20) begin
            tick();
            if (bus.o_state !== 3'd0 || bus.o_sfp_tx_disable !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch: %0d cycles left ABSENT, want 0", bad);
        end
        checks++;
        if (outs() !== 4'b1000) begin
            errors++;
            $display("FAIL glitch_outs: outs=%b, want 1000", outs());
        end
    endtask

    task automatic test_insertion();
        exp_t e;
        int   n;
        bus.i_sfp_los = 1'b0;
        bus.i_phy_rx_ready = 1'b1;
        bus.i_phy_tx_ready = 1'b1;
        bus.i_sfp_mod0_prsnt_n = 1'b0;
        sb.push_back(mk(3'd1, DB + 4, 2'd0));
        sb.push_back(mk(3'd2, TXD, 2'd0));
        sb.push_back(mk(3'd3, PR, 2'd0));
        sb.push_back(mk(3'd4, 1, 2'd0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_change(e.dly < 0 ? 30 : e.dly + 4, n);
            checks++;
            if (n !== e.dly || bus.o_state !== e.st || outs() !== e.o || bus.o_retry_count !== e.rc) begin
                errors++;
                $display("FAIL insert: st=%0d dly=%0d outs=%b rc=%0d, want st=%0d dly=%0d outs=%b rc=%0d",
                         bus.o_state, n, outs(), bus.o_retry_count, e.st, e.dly, e.o, e.rc);
            end
        end
    endtask

    task automatic test_los();
        exp_t e;
        int   n;
        int   rl0;
        rl0 = rl_cnt;
        sb.push_back(mk(3'd3, DB + 4, 2'd0));
        sb.push_back(mk(3'd4, DB + 4, 2'd0));
        fork
            begin
                bus.i_sfp_los = 1'b1;
                repeat (8) @(posedge clk);
                #1 bus.i_sfp_los = 1'b0;
            end
        join_none
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_change(e.dly < 0 ? 30 : e.dly + 4, n);
            checks++;
            if (n !== e.dly || bus.o_state !== e.st || outs() !== e.o || bus.o_retry_count !== e.rc) begin
                errors++;
                $display("FAIL los: st=%0d dly=%0d outs=%b rc=%0d, want st=%0d dly=%0d outs=%b rc=%0d",
                         bus.o_state, n, outs(), bus.o_retry_count, e.st, e.dly, e.o, e.rc);
            end
        end
        checks++;
        if (rl_cnt !== rl0) begin
            errors++;
            $display("FAIL los_no_phy_reset: reset-low cycles %0d, want %0d", rl_cnt, rl0);
        end
    endtask

    task automatic test_lock_timeout();
        exp_t e;
        int   n;
        sb.push_back(mk(3'd3, 2, 2'd0));
        sb.push_back(mk(3'd2, LT, 2'd0));
        sb.push_back(mk(3'd3, PR, 2'd0));
        sb.push_back(mk(3'd2, LT, 2'd0));
        sb.push_back(mk(3'd3, PR, 2'd0));
        sb.push_back(mk(3'd4, 2, 2'd0));
        fork
            begin
                bus.i_phy_rx_ready = 1'b0;
                repeat (2 + 2 * (LT + PR)) @(posedge clk);
                #1 bus.i_phy_rx_ready = 1'b1;
            end
        join_none
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_change(e.dly < 0 ? 30 : e.dly + 4, n);
            checks++;
            if (n !== e.dly || bus.o_state !== e.st || outs() !== e.o || bus.o_retry_count !== e.rc) begin
                errors++;
                $display("FAIL timeout: st=%0d dly=%0d outs=%b rc=%0d, want st=%0d dly=%0d outs=%b rc=%0d",
                         bus.o_state, n, outs(), bus.o_retry_count, e.st, e.dly, e.o, e.rc);
            end
        end
    endtask

    task automatic test_tx_fault();
        exp_t e;
        int   n;
        bus.i_sfp_tx_fault = 1'b1;
        sb.push_back(mk(3'd5, DB + 4, 2'd0));
`ifdef SFP_TX_FAULT_RETRY_EN
        sb.push_back(mk(3'd1, TXD, 2'd1));
        sb.push_back(mk(3'd2, TXD, 2'd1));
        sb.push_back(mk(3'd5, 1, 2'd1));
        sb.push_back(mk(3'd1, TXD, 2'd2));
        sb.push_back(mk(3'd2, TXD, 2'd2));
        sb.push_back(mk(3'd5, 1, 2'd2));
        sb.push_back(mk(3'd5, -1, 2'd2));
`else
        sb.push_back(mk(3'd5, -1, 2'd0));
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_change(e.dly < 0 ? 30 : e.dly + 4, n);
            checks++;
            if (n !== e.dly || bus.o_state !== e.st || outs() !== e.o || bus.o_retry_count !== e.rc) begin
                errors++;
                $display("FAIL tx_fault: st=%0d dly=%0d outs=%b rc=%0d, want st=%0d dly=%0d outs=%b rc=%0d",
                         bus.o_state, n, outs(), bus.o_retry_count, e.st, e.dly, e.o, e.rc);
            end
        end
    endtask

    task automatic test_removal();
        exp_t e;
        int   n;
        sb.push_back(mk(3'd0, DB + 4, 2'd0));
        sb.push_back(mk(3'd1, DB + 4, 2'd0));
        sb.push_back(mk(3'd2, TXD, 2'd0));
        sb.push_back(mk(3'd3, PR, 2'd0));
        sb.push_back(mk(3'd0, 5 + DB + 4, 2'd0));
        fork
            begin
                bus.i_sfp_mod0_prsnt_n = 1'b1;
                bus.i_sfp_tx_fault = 1'b0;
                bus.i_phy_rx_ready = 1'b0;
                repeat (DB + 4) @(posedge clk);
                #1 bus.i_sfp_mod0_prsnt_n = 1'b0;
                repeat (DB + 4 + TXD + PR + 5) @(posedge clk);
                #1 bus.i_sfp_mod0_prsnt_n = 1'b1;
            end
        join_none
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_change(e.dly < 0 ? 30 : e.dly + 4, n);
            checks++;
            if (n !== e.dly || bus.o_state !== e.st || outs() !== e.o || bus.o_retry_count !== e.rc) begin
                errors++;
                $display("FAIL removal: st=%0d dly=%0d outs=%b rc=%0d, want st=%0d dly=%0d outs=%b rc=%0d",
                         bus.o_state, n, outs(), bus.o_retry_count, e.st, e.dly, e.o, e.rc);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        sb.push_back(mk(3'd1, DB + 4, 2'd0));
        sb.push_back(mk(3'd2, TXD, 2'd0));
        sb.push_back(mk(3'd3, PR, 2'd0));
        sb.push_back(mk(3'd4, 1, 2'd0));
        sb.push_back(mk(3'd0, 1, 2'd0));
        sb.push_back(mk(3'd1, 2 + DB + 4, 2'd0));
        sb.push_back(mk(3'd2, TXD, 2'd0));
        sb.push_back(mk(3'd3, PR, 2'd0));
        sb.push_back(mk(3'd4, 1, 2'd0));
        fork
            begin
                bus.i_phy_rx_ready = 1'b1;
                bus.i_sfp_mod0_prsnt_n = 1'b0;
                repeat (DB + 4 + TXD + PR + 1) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join_none
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_change(e.dly < 0 ? 30 : e.dly + 4, n);
            checks++;
            if (n !== e.dly || bus.o_state !== e.st || outs() !== e.o || bus.o_retry_count !== e.rc) begin
                errors++;
                $display("FAIL reset_mid: st=%0d dly=%0d outs=%b rc=%0d, want st=%0d dly=%0d outs=%b rc=%0d",
                         bus.o_state, n, outs(), bus.o_retry_count, e.st, e.dly, e.o, e.rc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_insertion();
        test_los();
        test_lock_timeout();
        test_tx_fault();
        test_removal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
